// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] m_q, m_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, done_q, done_d;
  logic sa, sb, ge;
  logic [31:0] amag, bmag, diff, quo, rem;
  logic [32:0] sum;
  logic [63:0] mul_acc, div_acc, prod;
  always_comb begin
    sa = ~op[0] & a[31];
    sb = ~op[0] & b[31];
    amag = sa ? -a : a;
    bmag = sb ? -b : b;
    sum = {1'b0, acc_q[63:32]} + {1'b0, m_q};
    mul_acc = acc_q[0] ? {sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
    ge = {1'b0, acc_q[63:31]} >= {2'b0, m_q};
    diff = acc_q[62:31] - m_q;
    div_acc = ge ? {diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo = (sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0];
    rem = sa_q ? -acc_q[63:32] : acc_q[63:32];
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    m_d = m_q;
    a_d = a_q;
    div_d = div_q;
    sa_d = sa_q;
    sb_d = sb_q;
    dz_d = dz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      state_d = CALC;
      cnt_d = 5'd0;
      div_d = op[1];
      sa_d = sa;
      sb_d = sb;
      a_d = a;
      dz_d = b == 32'd0;
      m_d = op[1] ? bmag : amag;
      acc_d = {32'd0, op[1] ? amag : bmag};
    end
    if (state_q == IDLE && !start) begin
      hi_d = mthi ? wd : hi_q;
      lo_d = mtlo ? wd : lo_q;
    end
    if (state_q == CALC) begin
      acc_d = div_q ? div_acc : mul_acc;
      cnt_d = cnt_q + 5'd1;
      state_d = cnt_q == 5'd31 ? FIX : CALC;
    end
    if (state_q == FIX) begin
      state_d = IDLE;
      done_d = 1'b1;
      hi_d = !div_q ? prod[63:32] : dz_q ? a_q : rem;
      lo_d = !div_q ? prod[31:0] : dz_q ? 32'hFFFF_FFFF : quo;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 5'd0;
      acc_q <= 64'd0;
      m_q <= 32'd0;
      a_q <= 32'd0;
      div_q <= 1'b0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      m_q <= m_d;
      a_q <= a_d;
      div_q <= div_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0] op = 2'd0;
  logic [31:0] a = 32'd0, b = 32'd0, wd = 32'd0;
  logic busy, done;
  logic [31:0] hi, lo;
  int n_chk = 0, n_fail = 0;
  int remain = 0;
  logic [63:0] pend = 64'd0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic m_done = 1'b0;
  int lat, bc, dones;
  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    if (o == 2'd0) return 64'(sx * sy);
    if (o == 2'd1) return {32'd0, x} * {32'd0, y};
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (o == 2'd3) return {x % y, x / y};
    return {32'(sx % sy), 32'(sx / sy)};
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      remain = 0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (remain == 0) begin
        if (start) begin
          remain = 33;
          pend = ref_res(op, a, b);
        end else begin
          if (mthi) m_hi = wd;
          if (mtlo) m_lo = wd;
        end
      end else begin
        remain--;
        if (remain == 0) begin
          {m_hi, m_lo} = pend;
          m_done = 1'b1;
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 64'(busy), 64'(remain != 0));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit noise,
                       output int l, output int bcnt);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    l = 0;
    bcnt = 32'(busy);
    while (!done && l < 40) begin
      if (noise) begin
        start = ($urandom % 4) == 0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
        mthi = 1'($urandom);
        mtlo = 1'($urandom);
        wd = $urandom;
      end
      @(posedge clk);
      #1;
      l++;
      bcnt += 32'(busy);
    end
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    if (l >= 40) chk("done_timeout", 64'(l), 64'd33);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bc);
    chk("multu_lat", 64'(lat), 64'd33);
    chk("multu_busy_cycles", 64'(bc), 64'd33);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h1);
    do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, lat, bc);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bc);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    do_op(2'd3, 32'd100, 32'd7, 1'b0, lat, bc);
    chk("divu_hi", 64'(hi), 64'd2);
    chk("divu_lo", 64'(lo), 64'd14);
    do_op(2'd3, 32'd100, 32'd0, 1'b0, lat, bc);
    chk("divz_hi", 64'(hi), 64'd100);
    chk("divz_lo", 64'(lo), 64'hFFFF_FFFF);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bc);
    chk("divovf_hi", 64'(hi), 64'd0);
    chk("divovf_lo", 64'(lo), 64'h8000_0000);
    mthi = 1'b1;
    wd = 32'h1234;
    @(posedge clk);
    #1 mthi = 1'b0;
    mtlo = 1'b1;
    wd = 32'h5678;
    @(posedge clk);
    #1 mtlo = 1'b0;
    chk("mthi_rd", 64'(hi), 64'h1234);
    chk("mtlo_rd", 64'(lo), 64'h5678);
    mthi = 1'b1;
    mtlo = 1'b1;
    wd = 32'hA5A5_0F0F;
    @(posedge clk);
    #1 mthi = 1'b0;
    mtlo = 1'b0;
    chk("both_hi", 64'(hi), 64'hA5A5_0F0F);
    chk("both_lo", 64'(lo), 64'hA5A5_0F0F);
    mthi = 1'b1;
    wd = 32'hBEEF;
    start = 1'b1;
    op = 2'd1;
    a = 32'd3;
    b = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    mthi = 1'b0;
    chk("start_wins_hi", 64'(hi), 64'hA5A5_0F0F);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    op = 2'd2;
    a = 32'd1;
    b = 32'd1;
    mthi = 1'b1;
    wd = 32'hDEAD;
    @(posedge clk);
    #1 start = 1'b0;
    mthi = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1 dones += 32'(done);
    end
    chk("busy_test_dones", 64'(dones), 64'd1);
    chk("busy_test_hi", 64'(hi), 64'd0);
    chk("busy_test_lo", 64'(lo), 64'd12);
    start = 1'b1;
    op = 2'd0;
    a = 32'hFFFF_0003;
    b = 32'd77;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    do_op(2'd1, 32'd6, 32'd7, 1'b0, lat, bc);
    chk("post_rst_hi", 64'(hi), 64'd0);
    chk("post_rst_lo", 64'(lo), 64'd42);
    repeat (60) begin
      if ($urandom % 3 == 0) begin
        mthi = 1'($urandom);
        mtlo = 1'($urandom);
        wd = $urandom;
        @(posedge clk);
        #1 mthi = 1'b0;
        mtlo = 1'b0;
      end
      do_op(2'($urandom), pick(), pick(), 1'($urandom), lat, bc);
      chk("rand_lat", 64'(lat), 64'd33);
    end
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
